// File: rtl/mac_array_ctrl_if.sv
// Job, operand, mac_array and result signals of mac_array_ctrl.
// slave: the controller; master: scheduler/mac_array/writeback side.
interface mac_array_ctrl_if #(
  parameter int NUM_MAC   = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 8
);
  logic                         start;
  logic [LEN_WIDTH-1:0]         len;
  logic [NUM_MAC*ACC_WIDTH-1:0] bias;
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_MAC*IN_WIDTH-1:0]  in_a;
  logic [NUM_MAC*IN_WIDTH-1:0]  in_b;
  logic                         mac_en;
  logic [NUM_MAC*IN_WIDTH-1:0]  mac_a;
  logic [NUM_MAC*IN_WIDTH-1:0]  mac_b;
  logic [NUM_MAC*ACC_WIDTH-1:0] mac_acc_in;
  logic [NUM_MAC*ACC_WIDTH-1:0] mac_acc_out;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_MAC*ACC_WIDTH-1:0] out_acc;
  logic                         busy;

  modport slave (
    input  start, len, bias, in_valid, in_a, in_b, mac_acc_out, out_ready,
    output in_ready, mac_en, mac_a, mac_b, mac_acc_in, out_valid, out_acc, busy
  );

  modport master (
    output start, len, bias, in_valid, in_a, in_b, mac_acc_out, out_ready,
    input  in_ready, mac_en, mac_a, mac_b, mac_acc_in, out_valid, out_acc, busy
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// Dot-product job sequencer for mac_array; optional ReLU on output via MAC_ARRAY_CTRL_RELU_EN.
// Latency: 1 + len*(PIPE_LAT+2) cycles from start to out_valid; one beat per PIPE_LAT+2 cycles.
// Backpressure: in_ready only in ISSUE (stalls on in_valid low); result held while out_ready low.
module mac_array_ctrl #(
  parameter int NUM_MAC   = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 8,
  parameter int PIPE_LAT  = 2
) (
  input logic             clk,
  input logic             rst,
  mac_array_ctrl_if.slave bus
);
  localparam int LAT_W = $clog2(PIPE_LAT + 2);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, DONE} state_t;

  state_t                       state_q, state_d;
  logic [LEN_WIDTH-1:0]         cnt_q;
  logic [LAT_W-1:0]             lat_q;
  logic [NUM_MAC*ACC_WIDTH-1:0] acc_q;
  logic [NUM_MAC*IN_WIDTH-1:0]  mac_a_q, mac_b_q;
  logic [NUM_MAC*ACC_WIDTH-1:0] mac_acc_in_q;
  logic [NUM_MAC*ACC_WIDTH-1:0] out_acc_d;

  always_comb begin
    state_d      = state_q;
    bus.in_ready  = 1'b0;
    bus.mac_en    = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.len != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = EXEC;
      end
      EXEC: begin
        bus.mac_en = 1'b1;
        if (lat_q == LAT_LAST) state_d = (cnt_q != '0) ? ISSUE : DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_q        <= '0;
      acc_q        <= '0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_acc_in_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q <= bus.len;
            acc_q <= bus.bias;
          end
        end
        ISSUE: begin
          if (bus.in_valid) begin
            mac_a_q      <= bus.in_a;
            mac_b_q      <= bus.in_b;
            mac_acc_in_q <= acc_q;
            cnt_q        <= cnt_q - LEN_WIDTH'(1);
            lat_q        <= '0;
          end
        end
        EXEC: begin
          lat_q <= lat_q + LAT_W'(1);
          // mac_array result has settled by the final EXEC cycle
          if (lat_q == LAT_LAST) acc_q <= bus.mac_acc_out;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_acc_d = acc_q;
`ifdef MAC_ARRAY_CTRL_RELU_EN
    for (int l = 0; l < NUM_MAC; l++) begin
      if (acc_q[l*ACC_WIDTH + ACC_WIDTH-1]) out_acc_d[l*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
`else
`endif
  end

  assign bus.mac_a      = mac_a_q;
  assign bus.mac_b      = mac_b_q;
  assign bus.mac_acc_in = mac_acc_in_q;
  assign bus.out_acc    = out_acc_d;
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl with a behavioural 2-stage mac_array model.
module tb_mac_array_ctrl;
  bit   clk;
  logic rst;
  int   cyc;
  int   t_start;
  int   tests_run;
  int   fails;

  mac_array_ctrl_if #(.NUM_MAC(4), .IN_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)) bus ();

  mac_array_ctrl #(.NUM_MAC(4), .IN_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8), .PIPE_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mac_array model: acc_out = a*b + acc_in per lane (signed), two clock edges after sampling
  function automatic logic [15:0] mac_lane(input logic [7:0] a, input logic [7:0] b,
                                           input logic [15:0] acc);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return 16'(sa * sb) + acc;
  endfunction

  logic [63:0] mac_s1, mac_s2, mac_next;
  always_comb begin
    mac_next = '0;
    for (int l = 0; l < 4; l++)
      mac_next[l*16 +: 16] = mac_lane(bus.mac_a[l*8 +: 8], bus.mac_b[l*8 +: 8],
                                      bus.mac_acc_in[l*16 +: 16]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_s1 <= '0;
      mac_s2 <= '0;
    end else begin
      if (bus.mac_en) mac_s1 <= mac_next;
      mac_s2 <= mac_s1;
    end
  end
  assign bus.mac_acc_out = mac_s2;

  function automatic logic [63:0] rep16(input logic [15:0] v);
    return {4{v}};
  endfunction

  function automatic logic [31:0] rep8(input logic [7:0] v);
    return {4{v}};
  endfunction

  // All driver tasks start and end at a negedge.
  task automatic start_job(input logic [7:0] l, input logic [63:0] b);
    bus.start = 1'b1;
    bus.len   = l;
    bus.bias  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    t_start   = cyc;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok, output int lat);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid) begin
        ok  = 1'b1;
        lat = cyc - t_start + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.len   = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.in_ready, bus.mac_en, bus.out_valid, bus.busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, want 0000",
               {bus.in_ready, bus.mac_en, bus.out_valid, bus.busy});
    end
    tests_run++;
    if ({bus.mac_a, bus.mac_b, bus.mac_acc_in, bus.out_acc} !== '0) begin
      fails++;
      $display("FAIL reset_data: mac_a=%h mac_b=%h acc_in=%h out_acc=%h, want all 0",
               bus.mac_a, bus.mac_b, bus.mac_acc_in, bus.out_acc);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_start_ignored: busy=%b in_ready=%b, want 0 0", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_two_beat();
    bit ok1, ok2, ok;
    int lat;
    start_job(8'd2, '0);
    send_beat(32'h30410002, 32'h04030004, ok1);
    send_beat(32'h30410002, 32'h04030004, ok2);
    wait_valid(ok, lat);
    tests_run++;
    if (!(ok1 && ok2 && ok)) begin
      fails++;
      $display("FAIL two_beat_timeout: beat1=%0d beat2=%0d valid=%0d, want 1 1 1", ok1, ok2, ok);
    end
    tests_run++;
    if (lat !== 9) begin
      fails++;
      $display("FAIL two_beat_latency: got %0d, want 9", lat);
    end
    tests_run++;
    if (bus.out_acc !== {16'd384, 16'd390, 16'd0, 16'd16}) begin
      fails++;
      $display("FAIL two_beat_acc: got %h, want %h", bus.out_acc, {16'd384, 16'd390, 16'd0, 16'd16});
    end
    drain();
  endtask

  task automatic test_bias_zero_len();
    bit ok, ok1;
    int lat;
    start_job(8'd0, rep16(16'd5));
    wait_valid(ok, lat);
    tests_run++;
    if (!ok || lat !== 1) begin
      fails++;
      $display("FAIL zero_len_latency: got %0d (valid=%0d), want 1", lat, ok);
    end
    tests_run++;
    if (bus.out_acc !== rep16(16'd5)) begin
      fails++;
      $display("FAIL zero_len_acc: got %h, want %h", bus.out_acc, rep16(16'd5));
    end
    // start coinciding with DONE->IDLE must not launch a job
    bus.start     = 1'b1;
    bus.len       = 8'd0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_start_ignored: busy=%b out_valid=%b, want 0 0", bus.busy, bus.out_valid);
    end
    start_job(8'd1, rep16(16'd1));
    send_beat(rep8(8'd1), rep8(8'd1), ok1);
    wait_valid(ok, lat);
    tests_run++;
    if (!(ok && ok1) || bus.out_acc !== rep16(16'd2) || lat !== 5) begin
      fails++;
      $display("FAIL len1_bias: got acc=%h lat=%0d, want %h lat=5", bus.out_acc, lat, rep16(16'd2));
    end
    drain();
  endtask

  task automatic test_stalls();
    bit ok1, ok2, ok;
    int lat;
    bit stall_seen;
    bit stable;
    start_job(8'd2, '0);
    send_beat(32'h30410002, 32'h04030004, ok1);
    stall_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        stall_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!stall_seen) begin
      fails++;
      $display("FAIL stall_reach_issue: in_ready=%b, want 1", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.mac_en !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stall_mac_en: cycle %0d mac_en=%b in_ready=%b, want 0 1",
                 i, bus.mac_en, bus.in_ready);
      end
      @(negedge clk);
    end
    send_beat(32'h30410002, 32'h04030004, ok2);
    wait_valid(ok, lat);
    tests_run++;
    if (!(ok1 && ok2 && ok) || bus.out_acc !== {16'd384, 16'd390, 16'd0, 16'd16}) begin
      fails++;
      $display("FAIL stall_acc: got %h, want %h", bus.out_acc, {16'd384, 16'd390, 16'd0, 16'd16});
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_acc !== {16'd384, 16'd390, 16'd0, 16'd16})
        stable = 1'b0;
    end
    tests_run++;
    if (!stable) begin
      fails++;
      $display("FAIL out_hold: out_valid=%b out_acc=%h, want 1 %h",
               bus.out_valid, bus.out_acc, {16'd384, 16'd390, 16'd0, 16'd16});
    end
    drain();
  endtask

  task automatic test_relu();
    bit ok1, ok;
    int lat;
    logic [63:0] exp;
`ifdef MAC_ARRAY_CTRL_RELU_EN
    exp = 64'h0000_0000_0000_0000;
`else
    exp = 64'h0000_0000_0000_FFF4;
`endif
    start_job(8'd1, 64'h0000_0000_0000_FFF0);
    send_beat(32'h00000002, 32'h00000002, ok1);
    wait_valid(ok, lat);
    tests_run++;
    if (!(ok1 && ok) || bus.out_acc !== exp) begin
      fails++;
      $display("FAIL relu_lane0: got %h, want %h", bus.out_acc, exp);
    end
    drain();
  endtask

  task automatic test_mid_job_reset();
    bit ok1, ok;
    int lat;
    bit no_valid;
    start_job(8'd3, '0);
    bus.in_valid = 1'b1;
    bus.in_a     = rep8(8'd3);
    bus.in_b     = rep8(8'd3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.mac_en !== 1'b1) begin
      fails++;
      $display("FAIL midreset_in_exec: mac_en=%b, want 1", bus.mac_en);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.mac_en !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_idle: busy=%b mac_en=%b out_valid=%b, want 0 0 0",
               bus.busy, bus.mac_en, bus.out_valid);
    end
    no_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) no_valid = 1'b0;
    end
    tests_run++;
    if (!no_valid) begin
      fails++;
      $display("FAIL midreset_no_result: out_valid=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
    end
    start_job(8'd1, rep16(16'd1));
    send_beat(rep8(8'd1), rep8(8'd1), ok1);
    wait_valid(ok, lat);
    tests_run++;
    if (!(ok1 && ok) || bus.out_acc !== rep16(16'd2)) begin
      fails++;
      $display("FAIL midreset_fresh_job: got %h, want %h", bus.out_acc, rep16(16'd2));
    end
    drain();
  endtask

  initial begin
    tests_run     = 0;
    fails         = 0;
    cyc           = 0;
    t_start       = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_beat();
    test_bias_zero_len();
    test_stalls();
    test_relu();
    test_mid_job_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
